// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Shared definitions for the stopwatch counting core.
//   - sw_state_e : control state (IDLE, RUN, LAP, PAUSE), 2-bit encoding
//   - DEF_*      : default timing / range constants
//   - COUNT_W / NUMBER_W : internal count width and display bus width
//   - to_number(): zero-extends a count value onto the display bus
//   - is_counting(): true in the states where time advances
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } sw_state_e;

  localparam int DEF_TICKS_PER_COUNT = 10;
  localparam int DEF_MAX_COUNT       = 9999;
  localparam int DEF_DEBOUNCE_MS     = 20;

  localparam int COUNT_W  = 14;
  localparam int NUMBER_W = 16;

  function automatic logic [NUMBER_W-1:0] to_number(input logic [COUNT_W-1:0] v);
    return {{(NUMBER_W-COUNT_W){1'b0}}, v};
  endfunction

  function automatic logic is_counting(input sw_state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Two-flop synchroniser followed by a stability counter. The accepted level
//   only moves after DEBOUNCE_MS consecutive synchronised samples disagree with
//   it; any sample that agrees restarts the count. A 0->1 change of the
//   accepted level produces a single-cycle registered press pulse, which is
//   high during the cycle after the level rises. Releases produce no pulse.
//
//   Ports:
//     ms_clock : 1 kHz clock, rising edge
//     rst_n    : asynchronous active-low reset
//     raw      : raw button level, asynchronous to ms_clock
//     press    : one-cycle press pulse
// -----------------------------------------------------------------------------
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic ms_clock,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic [1:0]       sync_q;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;
  logic             sampled;

  assign sampled = sync_q[1];

  always_ff @(posedge ms_clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b00;
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      press  <= 1'b0;
      if (sampled != level) begin
        // This sample is the DEBOUNCE_MS-th disagreeing one in a row: accept.
        if (stable_cnt == CNT_LAST) begin
          level      <= sampled;
          stable_cnt <= '0;
          press      <= sampled;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctl
//   Stopwatch counting core feeding the 4-digit display controller. Debounces
//   three buttons and runs the IDLE/RUN/LAP/PAUSE control state machine, a
//   prescaler and the count/hold registers. `number` is registered and shows
//   hold while in LAP, the live count otherwise.
//
//   Parameters:
//     TICKS_PER_COUNT : ms_clock cycles per count increment
//     MAX_COUNT       : largest count value
//     DEBOUNCE_MS     : consecutive samples needed to accept a button level
//     WRAP            : 1 = wrap to 0 at MAX_COUNT, 0 = saturate and pause
//
//   Ports:
//     ms_clock       : 1 kHz clock, rising edge
//     rst_n          : asynchronous active-low reset; deassertion is expected
//                      to be aligned to ms_clock by the reset source
//     btn_start_stop : raw start/stop button, active-high
//     btn_lap        : raw lap button, active-high
//     btn_clear      : raw clear button, active-high
//     number         : value to display, 0..MAX_COUNT
//     running        : high in RUN or LAP
//     overflow       : sticky, set when the count saturates
//     dbg_state      : current control state, for observation only
// -----------------------------------------------------------------------------
module stopwatch_ctl
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_COUNT = DEF_TICKS_PER_COUNT,
  parameter int MAX_COUNT       = DEF_MAX_COUNT,
  parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter bit WRAP            = 1'b0
) (
  input  logic                ms_clock,
  input  logic                rst_n,
  input  logic                btn_start_stop,
  input  logic                btn_lap,
  input  logic                btn_clear,
  output logic [NUMBER_W-1:0] number,
  output logic                running,
  output logic                overflow,
  output sw_state_e           dbg_state
);

  localparam int PRE_W = (TICKS_PER_COUNT > 1) ? $clog2(TICKS_PER_COUNT) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICKS_PER_COUNT - 1);
  localparam logic [COUNT_W-1:0] MAX_C    = COUNT_W'(MAX_COUNT);

  // Press pulses
  logic start_stop_p;
  logic lap_p;
  logic clear_p;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_start_stop (
    .ms_clock (ms_clock),
    .rst_n    (rst_n),
    .raw      (btn_start_stop),
    .press    (start_stop_p)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_lap (
    .ms_clock (ms_clock),
    .rst_n    (rst_n),
    .raw      (btn_lap),
    .press    (lap_p)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_clear (
    .ms_clock (ms_clock),
    .rst_n    (rst_n),
    .raw      (btn_clear),
    .press    (clear_p)
  );

  sw_state_e          state;
  logic [PRE_W-1:0]   prescale;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] hold;

  logic               counting;
  logic               tick;
  logic               at_max;
  logic               saturate;
  logic [COUNT_W-1:0] count_inc;

  assign dbg_state = state;

  // Count value after this edge's prescaler tick, independent of buttons.
  always_comb begin
    counting  = is_counting(state);
    tick      = counting && (prescale == PRE_LAST);
    at_max    = (count >= MAX_C);
    saturate  = tick && at_max && !WRAP;
    count_inc = count;
    if (tick) begin
      if (!at_max) begin
        count_inc = count + COUNT_W'(1);
      end else if (WRAP) begin
        count_inc = '0;
      end
    end
  end

  // Control FSM with registered outputs. Button priority inside each state is
  // start_stop, then lap, then clear; pulses that lose are simply dropped.
  always_ff @(posedge ms_clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      prescale <= '0;
      count    <= '0;
      hold     <= '0;
      number   <= '0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (counting) begin
        prescale <= tick ? '0 : prescale + PRE_W'(1);
      end

      if (saturate) begin
        // Saturation overrides any button pulse seen on the same edge.
        state    <= ST_PAUSE;
        running  <= 1'b0;
        overflow <= 1'b1;
        count    <= count_inc;
        number   <= to_number(count_inc);
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_stop_p) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end

          ST_RUN: begin
            count <= count_inc;
            if (start_stop_p) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
              number  <= to_number(count_inc);
            end else if (lap_p) begin
              // Freeze the value the display is currently showing.
              state  <= ST_LAP;
              hold   <= count;
              number <= to_number(count);
            end else begin
              number <= to_number(count_inc);
            end
          end

          ST_LAP: begin
            count <= count_inc;
            if (start_stop_p) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
              number  <= to_number(count_inc);
            end else if (lap_p) begin
              state  <= ST_RUN;
              number <= to_number(count_inc);
            end else begin
              number <= to_number(hold);
            end
          end

          ST_PAUSE: begin
            if (start_stop_p) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end else if (clear_p) begin
              state    <= ST_IDLE;
              count    <= '0;
              prescale <= '0;
              overflow <= 1'b0;
              number   <= '0;
            end
          end

          default: begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctl
//   Three stopwatch instances share the clock, reset and buttons:
//     [0] MAX_COUNT 9999, saturating
//     [1] MAX_COUNT 15,   saturating
//     [2] MAX_COUNT 15,   wrapping
//   A reference model tracks elapsed running milliseconds per instance; the
//   count, prescaler phase, hold and overflow are derived from that with plain
//   arithmetic. Directed steps plus a randomized button phase.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctl;
  import stopwatch_pkg::*;

  localparam int TICKS     = 10;
  localparam int DB        = 4;
  localparam int PRESS_LAT = 2 + DB + 1;  // raw edge to pulse-sampling edge

  // Clock / reset
  logic ms_clock;
  logic rst_n;
  logic btn_start_stop;
  logic btn_lap;
  logic btn_clear;

  logic [2:0][15:0] number;
  logic [2:0]       running;
  logic [2:0]       overflow;
  sw_state_e        dbg_state [3];

  initial ms_clock = 1'b0;
  always #5 ms_clock = ~ms_clock;

  stopwatch_ctl #(.TICKS_PER_COUNT(TICKS), .MAX_COUNT(9999), .DEBOUNCE_MS(DB), .WRAP(1'b0)) dut_main (
    .ms_clock(ms_clock), .rst_n(rst_n), .btn_start_stop(btn_start_stop), .btn_lap(btn_lap),
    .btn_clear(btn_clear), .number(number[0]), .running(running[0]), .overflow(overflow[0]),
    .dbg_state(dbg_state[0]));

  stopwatch_ctl #(.TICKS_PER_COUNT(TICKS), .MAX_COUNT(15), .DEBOUNCE_MS(DB), .WRAP(1'b0)) dut_sat (
    .ms_clock(ms_clock), .rst_n(rst_n), .btn_start_stop(btn_start_stop), .btn_lap(btn_lap),
    .btn_clear(btn_clear), .number(number[1]), .running(running[1]), .overflow(overflow[1]),
    .dbg_state(dbg_state[1]));

  stopwatch_ctl #(.TICKS_PER_COUNT(TICKS), .MAX_COUNT(15), .DEBOUNCE_MS(DB), .WRAP(1'b1)) dut_wrap (
    .ms_clock(ms_clock), .rst_n(rst_n), .btn_start_stop(btn_start_stop), .btn_lap(btn_lap),
    .btn_clear(btn_clear), .number(number[2]), .running(running[2]), .overflow(overflow[2]),
    .dbg_state(dbg_state[2]));

  // Reference model
  sw_state_e m_mode   [3];
  int        m_run_ms [3];  // running milliseconds since last clear
  int        m_hold   [3];
  bit        m_ovf    [3];

  int checks;
  int errors;

  function automatic int max_of(input int i);
    return (i == 0) ? 9999 : 15;
  endfunction

  function automatic bit wrap_of(input int i);
    return (i == 2);
  endfunction

  function automatic int m_count(input int i);
    return m_run_ms[i] / TICKS;
  endfunction

  function automatic int exp_number(input int i);
    return (m_mode[i] == ST_LAP) ? m_hold[i] : m_count(i);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i]   = ST_IDLE;
      m_run_ms[i] = 0;
      m_hold[i]   = 0;
      m_ovf[i]    = 1'b0;
    end
  endfunction

  // One rising edge with the given press pulses being sampled.
  function automatic void model_edge(input int i, input bit ss, input bit lp, input bit cl);
    int  shown_before;
    bit  sat;
    shown_before = m_count(i);
    sat = 1'b0;
    if (m_mode[i] == ST_RUN || m_mode[i] == ST_LAP) begin
      m_run_ms[i]++;
      if (m_run_ms[i] == (max_of(i) + 1) * TICKS) begin
        if (wrap_of(i)) begin
          m_run_ms[i] = 0;
        end else begin
          m_run_ms[i] = max_of(i) * TICKS;
          sat = 1'b1;
        end
      end
    end
    if (sat) begin
      m_mode[i] = ST_PAUSE;
      m_ovf[i]  = 1'b1;
    end else begin
      case (m_mode[i])
        ST_IDLE:  if (ss) m_mode[i] = ST_RUN;
        ST_RUN:   if (ss) m_mode[i] = ST_PAUSE;
                  else if (lp) begin m_hold[i] = shown_before; m_mode[i] = ST_LAP; end
        ST_LAP:   if (ss) m_mode[i] = ST_PAUSE;
                  else if (lp) m_mode[i] = ST_RUN;
        default:  if (ss) m_mode[i] = ST_RUN;
                  else if (cl) begin m_mode[i] = ST_IDLE; m_run_ms[i] = 0; m_ovf[i] = 1'b0; end
      endcase
    end
  endfunction

  // Checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input logic [31:0] obs, input int lo, input int hi);
    checks++;
    assert (!$isunknown(obs) && int'(obs) >= lo && int'(obs) <= hi) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.number[%0d]", tag, i), {16'b0, number[i]}, 32'(exp_number(i)));
      chk($sformatf("%s.running[%0d]", tag, i), {31'b0, running[i]},
          {31'b0, (m_mode[i] == ST_RUN) || (m_mode[i] == ST_LAP)});
      chk($sformatf("%s.overflow[%0d]", tag, i), {31'b0, overflow[i]}, {31'b0, m_ovf[i]});
      chk($sformatf("%s.state[%0d]", tag, i), {30'b0, dbg_state[i]}, {30'b0, m_mode[i]});
    end
  endtask

  // Driver tasks: every task starts and ends on a falling edge.
  task automatic step(input bit ss, input bit lp, input bit cl);
    @(posedge ms_clock);
    for (int i = 0; i < 3; i++) model_edge(i, ss, lp, cl);
    @(negedge ms_clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input bit ss, input bit lp, input bit cl);
    btn_start_stop = ss;
    btn_lap        = lp;
    btn_clear      = cl;
    idle(PRESS_LAT - 1);
    step(ss, lp, cl);
    idle(3);
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
    idle(DB + 4);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int combo;
    int gap;
    checks = 0;
    errors = 0;
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
    rst_n          = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(negedge ms_clock);
    check_all("in_reset");
    rst_n = 1'b1;
    idle(50);
    check_all("reset_idle");
    for (int i = 0; i < 3; i++) chk($sformatf("reset_number[%0d]", i), {16'b0, number[i]}, 32'd0);

    // Debounce: bouncing start_stop, then held; RUN appears once, 7 edges
    // after the final rising edge (set before iteration 20).
    for (int c = 0; c < 30; c++) begin
      btn_start_stop = (c >= 20) ? 1'b1 : (((c / 2) % 2) == 0);
      step(c == 20 + PRESS_LAT - 1, 1'b0, 1'b0);
      chk($sformatf("debounce_state_c%0d", c), {30'b0, dbg_state[0]}, {30'b0, m_mode[0]});
      if (c == 20 + PRESS_LAT - 2)
        chk("debounce_not_early", {30'b0, dbg_state[0]}, {30'b0, ST_IDLE});
    end
    chk("debounce_run", {30'b0, dbg_state[0]}, {30'b0, ST_RUN});
    btn_start_stop = 1'b0;
    idle(DB + 4);
    check_all("debounce_done");

    // Saturation (instance 1) and wrap (instance 2)
    idle(200);
    check_all("sat");
    chk("sat_number", {16'b0, number[1]}, 32'd15);
    chk("sat_overflow", {31'b0, overflow[1]}, 32'd1);
    chk("sat_state", {30'b0, dbg_state[1]}, {30'b0, ST_PAUSE});
    chk("wrap_overflow", {31'b0, overflow[2]}, 32'd0);
    chk("wrap_running", {31'b0, running[2]}, 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check_all("sat_clear");
    chk("sat_clear_number", {16'b0, number[1]}, 32'd0);
    chk("sat_clear_overflow", {31'b0, overflow[1]}, 32'd0);

    // Basic count on instance 0 from zero
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check_all("cleared");
    press(1'b1, 1'b0, 1'b0);
    idle(1000 - PRESS_LAT - 3 - (DB + 4));
    press(1'b1, 1'b0, 1'b0);
    chk_range("basic_1000", {16'b0, number[0]}, 99, 101);
    check_all("basic_stop");
    idle(500);
    chk_range("basic_stable", {16'b0, number[0]}, 99, 101);
    check_all("basic_stable");
    press(1'b1, 1'b0, 1'b0);
    idle(50 - 3 - (DB + 4));
    chk("basic_resume", {16'b0, number[0]}, 32'd105);
    check_all("basic_resume");

    // Lap: hold while counting, then back to live count
    press(1'b0, 1'b1, 1'b0);
    check_all("lap_enter");
    idle(120);
    check_all("lap_frozen");
    press(1'b0, 1'b1, 1'b0);
    check_all("lap_exit");

    // Randomized button combinations and gaps
    for (int n = 0; n < 30; n++) begin
      combo = $urandom_range(1, 7);
      gap   = $urandom_range(0, 80);
      idle(gap);
      press(combo[0], combo[1], combo[2]);
      check_all($sformatf("rand%0d", n));
    end

    // Priority: start_stop and clear together in PAUSE -> RUN, count kept
    if (m_mode[0] == ST_LAP) press(1'b0, 1'b1, 1'b0);
    if (m_mode[0] == ST_IDLE) begin
      press(1'b1, 1'b0, 1'b0);
      idle(30);
    end
    if (m_mode[0] == ST_RUN) press(1'b1, 1'b0, 1'b0);
    check_all("prio_paused");
    chk("prio_pause_state", {30'b0, dbg_state[0]}, {30'b0, ST_PAUSE});
    press(1'b1, 1'b0, 1'b1);
    check_all("prio_both");
    chk("prio_state", {30'b0, dbg_state[0]}, {30'b0, ST_RUN});

    // Mid-run asynchronous reset at count 42
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 1000 && m_count(0) < 42; k++) idle(1);
    check_all("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_rst_number[%0d]", i), {16'b0, number[i]}, 32'd0);
      chk($sformatf("async_rst_running[%0d]", i), {31'b0, running[i]}, 32'd0);
      chk($sformatf("async_rst_overflow[%0d]", i), {31'b0, overflow[i]}, 32'd0);
    end
    @(negedge ms_clock);
    rst_n = 1'b1;
    idle(20);
    check_all("post_reset");
    press(1'b1, 1'b0, 1'b0);
    idle(35);
    check_all("post_reset_run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctl.md
# stopwatch_ctl

Stopwatch counting core that sits directly upstream of the 4-digit display controller. It debounces three push-buttons and runs a start/stop/lap/clear state machine. It produces the 16-bit binary `number` (0..9999, read as SS.cc) that the display stage splits into digits and multiplexes. It is clocked by the same 1 kHz `ms_clock` as the display.

## Interface
- `TICKS_PER_COUNT`, 10, `ms_clock` cycles per `number` increment (10 ms resolution).
- `MAX_COUNT`, 9999, largest value of the count.
- `DEBOUNCE_MS`, 20, consecutive identical raw samples required to accept a new button level.
- `WRAP`, 0, behaviour at `MAX_COUNT`: 1 wraps the count to 0; 0 saturates and auto-pauses.

Ports:
- `ms_clock`  in  1  1 kHz system clock; all flops rise-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_start_stop`  in  1  raw button, active-high, asynchronous to `ms_clock`.
- `btn_lap`  in  1  raw button, active-high.
- `btn_clear`  in  1  raw button, active-high.
- `number`  out  16  value to display, binary 0..`MAX_COUNT`.
- `running`  out  1  high in RUN or LAP.
- `overflow`  out  1  sticky; set on saturation.

## Operation
- **Input sync:** each button passes through a 2-flop synchroniser, then a debouncer.
- **Debouncer:** the accepted level changes only after `DEBOUNCE_MS` consecutive samples differ from it; any bounce restarts the count. A rising edge of the accepted level gives a one-cycle press pulse. Releases give no pulse.
- **Reset values:** state IDLE; count, prescaler, hold and `number` all 0; `running` 0; `overflow` 0; debouncer levels and counters 0.
- **IDLE:** count is 0. start_stop -> RUN. lap and clear are ignored.
- **RUN:** start_stop -> PAUSE. lap -> LAP and captures the count into hold. clear is ignored.
- **LAP:** counting continues and `number` shows hold. lap -> RUN. start_stop -> PAUSE and `number` returns to the live count. clear is ignored.
- **PAUSE:** start_stop -> RUN. clear -> IDLE and zeroes count, prescaler and `overflow`. lap is ignored.
- **Simultaneous pulses in one cycle:** start_stop wins, then lap, then clear. Losing pulses are dropped, not queued.
- **Prescaler:** runs 0..`TICKS_PER_COUNT`-1 in RUN and LAP only. At the terminal value it returns to 0 and the count increments. It holds its value in PAUSE, so a resume continues the partial period.
- **At `MAX_COUNT` with `WRAP`=1:** the count goes to 0 and `overflow` is unchanged.
- **At `MAX_COUNT` with `WRAP`=0:** the count stays at `MAX_COUNT`, `overflow` is set and the state forces to PAUSE on the same edge. That forced transition overrides any pulse in that cycle.
- **Width rules:** count and hold are 14 bits, zero-extended to 16 on `number`; count never exceeds `MAX_COUNT`.
- **`number` source:** registered; equals hold in LAP, the count otherwise.

## Timing
- Raw level to accepted level: 2 synchroniser cycles plus `DEBOUNCE_MS` cycles.
- The press pulse is high in the cycle after the accepted level rises.
- State, `running` and hold update on the edge that samples the pulse.
- Press to first count increment in RUN: `TICKS_PER_COUNT` cycles after the state change, when the prescaler starts at 0.
- `number` changes on the same edge as the count or hold; zero extra latency relative to the count register.
- `rst_n` asserted mid-run clears everything immediately, asynchronously. Deassertion is synchronised to `ms_clock`; the first state evaluation is on the next rising edge.
- A button held through reset release is accepted after the debounce period and counts as one press.

## Structure
- Shared package `stopwatch_pkg` holds:
  - the state typedef (IDLE, RUN, LAP, PAUSE; 2-bit encoding);
  - the default constants for ticks, max count and debounce.
- Sub-module `btn_debounce` (synchroniser, stability counter, press pulse), instantiated three times.
- The top level holds the FSM, prescaler, count/hold registers and output mux.

## Test plan
- **Reset values:** apply reset, release, idle 50 cycles -> `number`=0, `running`=0, `overflow`=0.
- **Debounce:** `DEBOUNCE_MS`=4; start_stop toggling every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one transition to RUN, 2+4+1 cycles after the last edge.
- **Basic count:** `TICKS_PER_COUNT`=10; press start, run 1000 cycles, press stop -> `number`=100 ±1 and stays stable for 500 cycles. Press start, run 50 cycles -> `number`=105.
- **Lap:** press lap at count 37 -> `number` holds 37 while the count advances. Press lap again at internal count 60 -> `number` shows 60 on the next edge.
- **Saturation:** `WRAP`=0, `MAX_COUNT`=15 -> count sticks at 15, `overflow`=1, state PAUSE. clear -> `number`=0, `overflow`=0. Repeat with `WRAP`=1 -> count goes 15 to 0 and keeps running.
- **Priority and mid-run reset:** start_stop and clear pulsed in the same cycle while in PAUSE -> RUN, count kept. `rst_n` low for 1 cycle in RUN at count 42 -> all outputs 0 immediately.
